// File: rtl/sm_clk_ctrl_if.sv
// Divisor configuration, run-control and tick bundle between the PIO core
// and the per-state-machine clock controller.
interface sm_clk_ctrl_if #(
  parameter int NUM_SM = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
);
  localparam int SM_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

  logic              cfg_wr_en;
  logic [SM_W-1:0]   cfg_sm;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic [INT_W-1:0]  cfg_rd_int;
  logic [FRAC_W-1:0] cfg_rd_frac;
  logic [NUM_SM-1:0] sm_enable;
  logic [NUM_SM-1:0] clkdiv_restart;
  logic [NUM_SM-1:0] sm_restart;
  logic [NUM_SM-1:0] sm_tick;
  logic [NUM_SM-1:0] sm_soft_rst;

  modport master (
    output cfg_wr_en, cfg_sm, cfg_int, cfg_frac,
    output sm_enable, clkdiv_restart, sm_restart,
    input  cfg_rd_int, cfg_rd_frac, sm_tick, sm_soft_rst
  );

  modport slave (
    input  cfg_wr_en, cfg_sm, cfg_int, cfg_frac,
    input  sm_enable, clkdiv_restart, sm_restart,
    output cfg_rd_int, cfg_rd_frac, sm_tick, sm_soft_rst
  );
endinterface

// File: rtl/sm_clk_ctrl.sv
// Per-state-machine fractional clock dividers producing sm_tick execute enables,
// plus divider phase restart and registered soft-restart pulses.
module sm_clk_ctrl #(
  parameter int NUM_SM = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sm_clk_ctrl_if.slave  bus
);
  localparam int SM_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

  logic [INT_W-1:0]  div_int  [NUM_SM];
  logic [FRAC_W-1:0] div_frac [NUM_SM];
  logic [INT_W-1:0]  cnt      [NUM_SM];
  logic [FRAC_W-1:0] acc      [NUM_SM];
  logic [FRAC_W:0]   acc_sum  [NUM_SM];
  logic [INT_W-1:0]  reload   [NUM_SM];
  logic [NUM_SM-1:0] tick;
  logic [NUM_SM-1:0] soft_rst;

  // div_int == 0 means 2^INT_W with no fraction, so its reload is all-ones and
  // carry is always 0; otherwise div_int-1+carry never exceeds INT_W bits.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SM; i++) begin
      acc_sum[i] = {1'b0, acc[i]};
      reload[i]  = '1;
      if (div_int[i] != '0) begin
        acc_sum[i] = {1'b0, acc[i]} + {1'b0, div_frac[i]};
        reload[i]  = div_int[i] - INT_W'(1) + INT_W'(acc_sum[i][FRAC_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SM; i++) begin
        div_int[i]  <= INT_W'(1);
        div_frac[i] <= '0;
        cnt[i]      <= '0;
        acc[i]      <= '0;
      end
      tick     <= '0;
      soft_rst <= '0;
    end else begin
      soft_rst <= bus.sm_restart;
      for (int unsigned i = 0; i < NUM_SM; i++) begin
        if (bus.cfg_wr_en && (bus.cfg_sm == SM_W'(i))) begin
          div_int[i]  <= bus.cfg_int;
          div_frac[i] <= bus.cfg_frac;
        end
        if (bus.clkdiv_restart[i]) begin
          cnt[i]  <= '0;
          acc[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (bus.sm_enable[i] && (cnt[i] == '0)) begin
          tick[i] <= 1'b1;
          acc[i]  <= acc_sum[i][FRAC_W-1:0];
          cnt[i]  <= reload[i];
        end else if (bus.sm_enable[i]) begin
          cnt[i]  <= cnt[i] - INT_W'(1);
          tick[i] <= 1'b0;
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.cfg_rd_int  = div_int[bus.cfg_sm];
  assign bus.cfg_rd_frac = div_frac[bus.cfg_sm];
  assign bus.sm_tick     = tick;
  assign bus.sm_soft_rst = soft_rst;
endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Self-checking bench for sm_clk_ctrl; the reference model schedules ticks as
// absolute due times counted in enabled cycles.
module tb_sm_clk_ctrl;
  localparam int NUM_SM = 4;
  localparam int INT_W  = 16;
  localparam int FRAC_W = 8;
  localparam int SM_W   = 2;
  localparam longint FSCALE = longint'(1) << FRAC_W;
  localparam longint IMAX   = longint'(1) << INT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sm_clk_ctrl_if #(.NUM_SM(NUM_SM), .INT_W(INT_W), .FRAC_W(FRAC_W)) bus ();

  sm_clk_ctrl #(.NUM_SM(NUM_SM), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned       m_int  [NUM_SM];
  int unsigned       m_frac [NUM_SM];
  longint            m_ecnt [NUM_SM];
  longint            m_due  [NUM_SM];
  longint            m_fsum [NUM_SM];
  logic [NUM_SM-1:0] exp_tick;
  logic [NUM_SM-1:0] exp_soft;

  task automatic model_reset();
    for (int i = 0; i < NUM_SM; i++) begin
      m_int[i] = 1; m_frac[i] = 0;
      m_ecnt[i] = 0; m_due[i] = 0; m_fsum[i] = 0;
    end
    exp_tick = '0;
    exp_soft = '0;
  endtask

  // Tick k after a phase origin is due once the machine has been enabled for
  // sum(int_eff) + floor(total_frac / 2^FRAC_W) cycles.
  task automatic model_edge();
    longint eff, f;
    for (int i = 0; i < NUM_SM; i++) begin
      eff = (m_int[i] == 0) ? IMAX : longint'(m_int[i]);
      f   = (m_int[i] == 0) ? 0 : longint'(m_frac[i]);
      if (bus.clkdiv_restart[i]) begin
        m_ecnt[i] = 0; m_due[i] = 0; m_fsum[i] = 0;
        exp_tick[i] = 1'b0;
      end else if (bus.sm_enable[i]) begin
        exp_tick[i] = (m_ecnt[i] == m_due[i]);
        if (exp_tick[i]) begin
          m_due[i]  = m_due[i] + eff + (m_fsum[i] + f) / FSCALE - m_fsum[i] / FSCALE;
          m_fsum[i] = m_fsum[i] + f;
        end
        m_ecnt[i]++;
      end else begin
        exp_tick[i] = 1'b0;
      end
    end
    if (bus.cfg_wr_en) begin
      m_int[bus.cfg_sm]  = int'(bus.cfg_int);
      m_frac[bus.cfg_sm] = int'(bus.cfg_frac);
    end
    exp_soft = bus.sm_restart;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.cfg_wr_en = 1'b0; bus.cfg_sm = '0; bus.cfg_int = '0; bus.cfg_frac = '0;
    bus.sm_enable = '0; bus.clkdiv_restart = '0; bus.sm_restart = '0;
  endtask

  task automatic cfg_write(input int sm, input int iv, input int fv);
    bus.cfg_wr_en = 1'b1; bus.cfg_sm = SM_W'(sm);
    bus.cfg_int = INT_W'(iv); bus.cfg_frac = FRAC_W'(fv);
    step();
    bus.cfg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.sm_tick !== '0) begin
      errors++; $display("FAIL reset_tick got %b exp %b", bus.sm_tick, 4'b0);
    end
    checks++;
    if (bus.sm_soft_rst !== '0) begin
      errors++; $display("FAIL reset_soft got %b exp %b", bus.sm_soft_rst, 4'b0);
    end
    for (int i = 0; i < NUM_SM; i++) begin
      bus.cfg_sm = SM_W'(i);
      #1;
      checks++;
      if (bus.cfg_rd_int !== INT_W'(1) || bus.cfg_rd_frac !== '0) begin
        errors++; $display("FAIL reset_rd sm %0d got %0d/%0d exp 1/0", i, bus.cfg_rd_int, bus.cfg_rd_frac);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_div1();
    bus.sm_enable = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (bus.sm_tick !== exp_tick || bus.sm_tick !== 4'b0001) begin
        errors++; $display("FAIL div1_tick cyc %0d got %b exp %b", k, bus.sm_tick, exp_tick);
      end
    end
  endtask

  task automatic test_frac();
    int n;
    cfg_write(1, 2, 128);
    checks++;
    if (bus.cfg_rd_int !== INT_W'(2) || bus.cfg_rd_frac !== FRAC_W'(128)) begin
      errors++; $display("FAIL frac_rd got %0d/%0d exp 2/128", bus.cfg_rd_int, bus.cfg_rd_frac);
    end
    bus.sm_enable = 4'b0011;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (bus.sm_tick !== exp_tick) begin
        errors++; $display("FAIL frac_tick cyc %0d got %b exp %b", k, bus.sm_tick, exp_tick);
      end
      n += int'(bus.sm_tick[1]);
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL frac_count got %0d exp 8", n);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NUM_SM; i++) begin
        bus.sm_enable[i]      = ($urandom_range(0, 9) < 8);
        bus.clkdiv_restart[i] = ($urandom_range(0, 39) == 0);
        bus.sm_restart[i]     = ($urandom_range(0, 9) == 0);
      end
      bus.cfg_sm    = SM_W'($urandom_range(0, NUM_SM - 1));
      bus.cfg_wr_en = ($urandom_range(0, 15) == 0);
      bus.cfg_int   = INT_W'($urandom_range(1, 5));
      bus.cfg_frac  = FRAC_W'($urandom_range(0, 255));
      step();
      checks++;
      if (bus.sm_tick !== exp_tick) begin
        errors++; $display("FAIL rand_tick cyc %0d got %b exp %b", k, bus.sm_tick, exp_tick);
      end
      checks++;
      if (bus.sm_soft_rst !== exp_soft) begin
        errors++; $display("FAIL rand_soft cyc %0d got %b exp %b", k, bus.sm_soft_rst, exp_soft);
      end
      checks++;
      if (bus.cfg_rd_int !== INT_W'(m_int[bus.cfg_sm]) || bus.cfg_rd_frac !== FRAC_W'(m_frac[bus.cfg_sm])) begin
        errors++; $display("FAIL rand_rd cyc %0d got %0d/%0d exp %0d/%0d", k, bus.cfg_rd_int,
                           bus.cfg_rd_frac, m_int[bus.cfg_sm], m_frac[bus.cfg_sm]);
      end
    end
    drive_idle();
  endtask

  task automatic test_phase();
    logic exp_t;
    drive_idle();
    cfg_write(0, 4, 0);
    cfg_write(3, 4, 0);
    bus.sm_enable = 4'b0001;
    repeat (2) step();
    bus.sm_enable = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.sm_tick !== exp_tick) begin
        errors++; $display("FAIL phase_pre cyc %0d got %b exp %b", k, bus.sm_tick, exp_tick);
      end
    end
    bus.clkdiv_restart = 4'b1001;
    step();
    bus.clkdiv_restart = '0;
    checks++;
    if (bus.sm_tick !== 4'b0000) begin
      errors++; $display("FAIL phase_restart got %b exp 0000", bus.sm_tick);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      exp_t = ((k % 4) == 0);
      checks++;
      if (bus.sm_tick !== exp_tick || bus.sm_tick !== {exp_t, 2'b00, exp_t}) begin
        errors++; $display("FAIL phase_align cyc %0d got %b exp %b", k, bus.sm_tick, {exp_t, 2'b00, exp_t});
      end
    end
  endtask

  task automatic test_pause();
    int c;
    bit seen;
    drive_idle();
    cfg_write(1, 5, 0);
    bus.clkdiv_restart = 4'b0010;
    bus.sm_enable = 4'b0010;
    step();
    bus.clkdiv_restart = '0;
    step();
    checks++;
    if (bus.sm_tick !== 4'b0010) begin
      errors++; $display("FAIL pause_first got %b exp 0010", bus.sm_tick);
    end
    c = 0;
    repeat (2) begin step(); c++; end
    bus.sm_enable = '0;
    for (int k = 0; k < 7; k++) begin
      step(); c++;
      checks++;
      if (bus.sm_tick !== '0 || exp_tick !== '0) begin
        errors++; $display("FAIL pause_off cyc %0d got %b exp 0000", k, bus.sm_tick);
      end
    end
    bus.sm_enable = 4'b0010;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      step(); c++;
      checks++;
      if (bus.sm_tick !== exp_tick) begin
        errors++; $display("FAIL pause_resume cyc %0d got %b exp %b", k, bus.sm_tick, exp_tick);
      end
      seen = bus.sm_tick[1];
    end
    checks++;
    if (!seen || c != 12) begin
      errors++; $display("FAIL pause_gap got %0d (seen %0d) exp 12", c, seen);
    end
    bus.sm_restart = 4'b0010;
    step();
    bus.sm_restart = '0;
    c = 1;
    checks++;
    if (bus.sm_soft_rst !== 4'b0010) begin
      errors++; $display("FAIL soft_pulse got %b exp 0010", bus.sm_soft_rst);
    end
    step(); c++;
    checks++;
    if (bus.sm_soft_rst !== 4'b0000) begin
      errors++; $display("FAIL soft_clear got %b exp 0000", bus.sm_soft_rst);
    end
    seen = bus.sm_tick[1];
    for (int k = 0; k < 50 && !seen; k++) begin
      step(); c++;
      seen = bus.sm_tick[1];
    end
    checks++;
    if (!seen || c != 5) begin
      errors++; $display("FAIL soft_cadence got %0d (seen %0d) exp 5", c, seen);
    end
  endtask

  task automatic test_wide();
    int c, g;
    int gaps [3];
    drive_idle();
    cfg_write(2, 0, 0);
    checks++;
    if (bus.cfg_rd_int !== '0) begin
      errors++; $display("FAIL wide_rd got %0d exp 0", bus.cfg_rd_int);
    end
    bus.clkdiv_restart = 4'b0100;
    bus.sm_enable = 4'b0100;
    step();
    bus.clkdiv_restart = '0;
    checks++;
    if (bus.sm_tick !== '0) begin
      errors++; $display("FAIL wide_restart_wins got %b exp 0000", bus.sm_tick);
    end
    step();
    checks++;
    if (bus.sm_tick !== 4'b0100) begin
      errors++; $display("FAIL wide_first got %b exp 0100", bus.sm_tick);
    end
    bus.cfg_sm = 2'd2; bus.cfg_int = INT_W'(3); bus.cfg_frac = '0;
    c = 0; g = 0;
    for (int k = 0; k < 70000 && g < 3; k++) begin
      bus.cfg_wr_en = (g == 0 && c == 100);
      step(); c++;
      checks++;
      if (bus.sm_tick !== exp_tick) begin
        errors++; $display("FAIL wide_tick cyc %0d got %b exp %b", k, bus.sm_tick, exp_tick);
      end
      if (bus.sm_tick[2]) begin
        gaps[g] = c; g++; c = 0;
      end
    end
    bus.cfg_wr_en = 1'b0;
    checks++;
    if (g != 3) begin
      errors++; $display("FAIL wide_timeout got %0d gaps exp 3", g);
    end else begin
      checks++;
      if (gaps[0] != 65536 || gaps[1] != 3 || gaps[2] != 3) begin
        errors++; $display("FAIL wide_gaps got %0d,%0d,%0d exp 65536,3,3", gaps[0], gaps[1], gaps[2]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_idle();
    cfg_write(0, 1, 0);
    bus.sm_enable = 4'b0001;
    repeat (3) step();
    bus.sm_restart = 4'b0001;
    step();
    checks++;
    if (bus.sm_tick !== 4'b0001 || bus.sm_soft_rst !== 4'b0001) begin
      errors++; $display("FAIL arst_pre got %b/%b exp 0001/0001", bus.sm_tick, bus.sm_soft_rst);
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.sm_tick !== '0 || bus.sm_soft_rst !== '0) begin
      errors++; $display("FAIL arst_drop got %b/%b exp 0000/0000", bus.sm_tick, bus.sm_soft_rst);
    end
    for (int i = 0; i < NUM_SM; i++) begin
      bus.cfg_sm = SM_W'(i);
      #1;
      checks++;
      if (bus.cfg_rd_int !== INT_W'(1) || bus.cfg_rd_frac !== '0) begin
        errors++; $display("FAIL arst_rd sm %0d got %0d/%0d exp 1/0", i, bus.cfg_rd_int, bus.cfg_rd_frac);
      end
    end
    bus.sm_restart = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.sm_tick !== exp_tick) begin
        errors++; $display("FAIL arst_resume cyc %0d got %b exp %b", k, bus.sm_tick, exp_tick);
      end
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_div1();
    test_frac();
    test_random();
    test_phase();
    test_pause();
    test_wide();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
